// File: rtl/banked_capture_ram.sv
// ---------------------------------------------------------------------------
// banked_capture_ram
//
// Sample memory for the analyzer capture path. A linear capture address space
// of DEPTH = NBANKS * 2^BANK_AW entries is split across NBANKS synchronous RAM
// banks. The upper address bits select the bank and the low BANK_AW bits form
// the offset within it. Samples are written through an auto-incrementing
// write pointer that wraps at DEPTH. A streaming engine replays the stored
// samples oldest-first over a valid/ready handshake, and a 3-entry output
// buffer absorbs backpressure.
//
// Ports:
//   CLK       clock, rising edge
//   RESETN    asynchronous active-low reset
//   CLR       synchronous clear of pointers/flags; aborts readout, no RD_DONE
//   WR_EN     store WR_DATA at the write pointer (IDLE only)
//   WR_DATA   sample to store (DW bits)
//   RD_START  pulse: start an oldest-first readout (IDLE only)
//   RD_DATA   readout sample (head of the output buffer)
//   RD_VALID  RD_DATA valid
//   RD_READY  consumer accepts RD_DATA
//   RD_DONE   one-cycle pulse when the readout is complete
//   BUSY      readout in progress
//   WRAPPED   sticky: the write pointer has wrapped at least once
//   COUNT     number of stored samples
// ---------------------------------------------------------------------------
module banked_capture_ram #(
    parameter int DW      = 9,
    parameter int BANK_AW = 11,
    parameter int NBANKS  = 3
) (
    input  logic                                          CLK,
    input  logic                                          RESETN,
    input  logic                                          CLR,
    input  logic                                          WR_EN,
    input  logic [DW-1:0]                                 WR_DATA,
    input  logic                                          RD_START,
    output logic [DW-1:0]                                 RD_DATA,
    output logic                                          RD_VALID,
    input  logic                                          RD_READY,
    output logic                                          RD_DONE,
    output logic                                          BUSY,
    output logic                                          WRAPPED,
    output logic [$clog2(NBANKS*(2**BANK_AW)+1)-1:0]      COUNT
);

    localparam int DEPTH = NBANKS * (2 ** BANK_AW);
    localparam int BSZ   = 2 ** BANK_AW;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of two).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : (p + PW'(1));
    endfunction

    // Bank index is the address divided by the bank depth.
    function automatic logic [2:0] bank_of(input logic [PW-1:0] p);
        bank_of = 3'(p >> BANK_AW);
    endfunction

    state_t              state_q, state_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic                wrapped_q, wrapped_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       remaining_q, remaining_d;
    logic                in_flight_q, in_flight_d;
    logic [2:0]          rd_bank_q, rd_bank_d;
    logic [DW-1:0]       buf_q [3];
    logic [DW-1:0]       buf_d [3];
    logic [1:0]          occ_q, occ_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_done_q, rd_done_d;
    logic                busy_q, busy_d;

    logic [CW-1:0]       count_s;
    logic                wr_fire_s;
    logic                rd_issue_s;
    logic                pop_s;
    logic [2:0]          occ_sum_s;
    logic [1:0]          occ_p_s;
    logic [DW-1:0]       ret_data_s;
    logic [DW-1:0]       bank_rdata_s [NBANKS];
    logic [2:0]          wr_bank_s, rd_bank_s;
    logic [BANK_AW-1:0]  wr_off_s, rd_off_s;

    assign count_s   = wrapped_q ? CW'(DEPTH) : CW'(wr_ptr_q);
    assign wr_bank_s = bank_of(wr_ptr_q);
    assign rd_bank_s = bank_of(rd_ptr_q);
    assign wr_off_s  = wr_ptr_q[BANK_AW-1:0];
    assign rd_off_s  = rd_ptr_q[BANK_AW-1:0];

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        logic [DW-1:0] mem_q [BSZ];
        logic [DW-1:0] rdata_q;

        // One synchronous RAM bank; only touched when the address selects it.
        always_ff @(posedge CLK) begin
            if (wr_fire_s && (wr_bank_s == 3'(b))) begin
                mem_q[wr_off_s] <= WR_DATA;
            end
            if (rd_issue_s && (rd_bank_s == 3'(b))) begin
                rdata_q <= mem_q[rd_off_s];
            end
        end

        assign bank_rdata_s[b] = rdata_q;
    end

    // Read-return mux keyed by the bank select of the previous cycle; codes
    // with no bank behind them return zero.
    always_comb begin
        ret_data_s = {DW{1'b0}};
        for (int i = 0; i < NBANKS; i++) begin
            ret_data_s = (rd_bank_q == 3'(i)) ? bank_rdata_s[i] : ret_data_s;
        end
    end

    // Next-state, pointer and output-buffer logic.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wrapped_d   = wrapped_q;
        rd_ptr_d    = rd_ptr_q;
        remaining_d = remaining_q;
        in_flight_d = 1'b0;
        rd_bank_d   = rd_bank_q;
        buf_d       = buf_q;
        occ_d       = occ_q;
        wr_fire_s   = 1'b0;
        rd_issue_s  = 1'b0;
        pop_s       = rd_valid_q && RD_READY;
        occ_p_s     = occ_q - {1'b0, pop_s};
        // Occupancy once this cycle's pop and returning read have settled.
        occ_sum_s   = {1'b0, occ_p_s} + {2'b00, in_flight_q};

        if (CLR) begin
            state_d     = ST_IDLE;
            wr_ptr_d    = {PW{1'b0}};
            wrapped_d   = 1'b0;
            rd_ptr_d    = {PW{1'b0}};
            remaining_d = {CW{1'b0}};
            occ_d       = 2'd0;
            buf_d       = '{default: {DW{1'b0}}};
        end else begin
            // Shift out the head on a transfer, then append the returning read.
            buf_d[0] = pop_s ? buf_q[1] : buf_q[0];
            buf_d[1] = pop_s ? buf_q[2] : buf_q[1];
            buf_d[2] = pop_s ? {DW{1'b0}} : buf_q[2];
            for (int i = 0; i < 3; i++) begin
                buf_d[i] = (in_flight_q && (occ_p_s == 2'(i))) ? ret_data_s : buf_d[i];
            end
            occ_d = occ_sum_s[1:0];

            case (state_q)
                ST_IDLE: begin
                    if (RD_START) begin
                        if (count_s == {CW{1'b0}}) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d     = ST_READ;
                            rd_ptr_d    = wrapped_q ? wr_ptr_q : {PW{1'b0}};
                            remaining_d = count_s;
                        end
                    end else if (WR_EN) begin
                        wr_fire_s = 1'b1;
                        wr_ptr_d  = ptr_inc(wr_ptr_q);
                        wrapped_d = wrapped_q || (wr_ptr_q == PW'(DEPTH - 1));
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_READ: begin
                    // Issue only if the data will have a buffer slot on return.
                    rd_issue_s = (remaining_q != {CW{1'b0}}) && (occ_sum_s < 3'd3);
                    if (rd_issue_s) begin
                        rd_ptr_d    = ptr_inc(rd_ptr_q);
                        remaining_d = remaining_q - CW'(1);
                        rd_bank_d   = rd_bank_s;
                        in_flight_d = 1'b1;
                    end else begin
                        in_flight_d = 1'b0;
                    end
                    if ((remaining_q == {CW{1'b0}}) && !in_flight_q && (occ_sum_s == 3'd0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        rd_valid_d = (occ_d != 2'd0);
        busy_d     = (state_d == ST_READ);
        rd_done_d  = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= {PW{1'b0}};
            wrapped_q   <= 1'b0;
            rd_ptr_q    <= {PW{1'b0}};
            remaining_q <= {CW{1'b0}};
            in_flight_q <= 1'b0;
            rd_bank_q   <= 3'd0;
            buf_q       <= '{default: {DW{1'b0}}};
            occ_q       <= 2'd0;
            rd_valid_q  <= 1'b0;
            rd_done_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wrapped_q   <= wrapped_d;
            rd_ptr_q    <= rd_ptr_d;
            remaining_q <= remaining_d;
            in_flight_q <= in_flight_d;
            rd_bank_q   <= rd_bank_d;
            buf_q       <= buf_d;
            occ_q       <= occ_d;
            rd_valid_q  <= rd_valid_d;
            rd_done_q   <= rd_done_d;
            busy_q      <= busy_d;
        end
    end

    assign RD_DATA  = buf_q[0];
    assign RD_VALID = rd_valid_q;
    assign RD_DONE  = rd_done_q;
    assign BUSY     = busy_q;
    assign WRAPPED  = wrapped_q;
    assign COUNT    = count_s;

endmodule

// File: tb/tb_banked_capture_ram.sv
`timescale 1ns/1ps
module tb_banked_capture_ram;
    localparam int DW      = 9;
    localparam int BAW     = 4;
    localparam int NB      = 3;
    localparam int DEPTH   = NB * (2 ** BAW);
    localparam int CW      = $clog2(DEPTH + 1);
    localparam int S_BAW   = 3;
    localparam int S_NB    = 1;
    localparam int S_DEPTH = S_NB * (2 ** S_BAW);
    localparam int S_CW    = $clog2(S_DEPTH + 1);

    logic clk = 1'b0;
    logic rst_n;
    logic clr, wr_en, rd_start, rd_ready;
    logic [DW-1:0] wr_data, rd_data;
    logic rd_valid, rd_done, busy, wrapped;
    logic [CW-1:0] count;

    logic s_clr, s_wr_en, s_rd_start, s_rd_ready;
    logic [DW-1:0] s_wr_data, s_rd_data;
    logic s_rd_valid, s_rd_done, s_busy, s_wrapped;
    logic [S_CW-1:0] s_count;

    int errors = 0;
    int checks = 0;

    // Reference model: the samples still stored are the most recent DEPTH writes.
    logic [DW-1:0] model_q[$];
    int model_total;
    logic [DW-1:0] got_q[$];
    int done_cnt, done_k, valid_cnt, first_valid_k, last_beat_k, stab_viol;
    logic busy_at_wr, timed_out;

    always #5 clk = ~clk;

    banked_capture_ram #(.DW(DW), .BANK_AW(BAW), .NBANKS(NB)) dut (
        .CLK(clk), .RESETN(rst_n), .CLR(clr), .WR_EN(wr_en), .WR_DATA(wr_data),
        .RD_START(rd_start), .RD_DATA(rd_data), .RD_VALID(rd_valid), .RD_READY(rd_ready),
        .RD_DONE(rd_done), .BUSY(busy), .WRAPPED(wrapped), .COUNT(count)
    );

    banked_capture_ram #(.DW(DW), .BANK_AW(S_BAW), .NBANKS(S_NB)) dut_s (
        .CLK(clk), .RESETN(rst_n), .CLR(s_clr), .WR_EN(s_wr_en), .WR_DATA(s_wr_data),
        .RD_START(s_rd_start), .RD_DATA(s_rd_data), .RD_VALID(s_rd_valid), .RD_READY(s_rd_ready),
        .RD_DONE(s_rd_done), .BUSY(s_busy), .WRAPPED(s_wrapped), .COUNT(s_count)
    );

    function automatic void model_write(input logic [DW-1:0] d);
        model_q.push_back(d);
        if (model_q.size() > DEPTH) void'(model_q.pop_front());
        model_total++;
    endfunction

    task automatic write_one(input logic [DW-1:0] d);
        wr_en = 1'b1;
        wr_data = d;
        model_write(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_q.delete();
        model_total = 0;
    endtask

    // Start a readout and collect the accepted beats; optional WR_EN pulse at cycle wr_at.
    task automatic do_readout(input int bp, input int wr_at, input int budget);
        logic prev_hold;
        logic [DW-1:0] prev_data;
        got_q.delete();
        done_cnt = 0; done_k = -1; valid_cnt = 0; first_valid_k = -1; last_beat_k = -1;
        stab_viol = 0; busy_at_wr = 1'b0; timed_out = 1'b1;
        prev_hold = 1'b0; prev_data = '0;
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            if (prev_hold && (!rd_valid || rd_data !== prev_data)) stab_viol++;
            if (rd_valid) valid_cnt++;
            if (rd_valid && first_valid_k < 0) first_valid_k = k;
            if (rd_done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            rd_ready = (bp != 0) ? ($urandom_range(0, 2) == 0) : 1'b1;
            if (rd_valid && rd_ready) begin
                got_q.push_back(rd_data);
                last_beat_k = k;
            end
            prev_hold = rd_valid && !rd_ready;
            prev_data = rd_data;
            wr_en = (k == wr_at);
            wr_data = 9'h1FF;
            if (k == wr_at) busy_at_wr = busy;
            @(negedge clk);
            if (done_k >= 0 && k >= done_k + 3) begin
                timed_out = 1'b0;
                break;
            end
        end
        wr_en = 1'b0;
        rd_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_data = '0; rd_start = 1'b0; rd_ready = 1'b1;
        s_clr = 1'b0; s_wr_en = 1'b0; s_wr_data = '0; s_rd_start = 1'b0; s_rd_ready = 1'b1;
        model_q.delete(); model_total = 0;
        repeat (3) @(negedge clk);
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        checks++; if (rd_done !== 1'b0) begin errors++; $display("FAIL reset_rd_done: got %b expected 0", rd_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rd_data !== 9'h000) begin errors++; $display("FAIL reset_rd_data: got %h expected 000", rd_data); end
        checks++; if (count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (wrapped !== 1'b0) begin errors++; $display("FAIL reset_wrapped: got %b expected 0", wrapped); end
        checks++; if (s_rd_valid !== 1'b0 || s_count !== 4'd0) begin
            errors++; $display("FAIL reset_small: valid %b count %0d expected 0 0", s_rd_valid, s_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_empty_readout();
        do_readout(0, 0, 20);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL empty_timeout: no RD_DONE within budget"); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL empty_done_cnt: got %0d expected 1", done_cnt); end
        checks++; if (done_k > 2) begin errors++; $display("FAIL empty_done_latency: got %0d expected <=2", done_k); end
        checks++; if (valid_cnt != 0) begin errors++; $display("FAIL empty_valid: got %0d valid cycles expected 0", valid_cnt); end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 10; i++) write_one(DW'(9'h100 + i));
        checks++; if (count !== CW'(model_q.size())) begin errors++; $display("FAIL basic_count: got %0d expected %0d", count, model_q.size()); end
        checks++; if (wrapped !== 1'b0) begin errors++; $display("FAIL basic_wrapped: got %b expected 0", wrapped); end
        do_readout(0, 3, 100);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL basic_timeout: no RD_DONE within budget"); end
        checks++; if (busy_at_wr !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy_at_wr); end
        checks++; if (got_q.size() != model_q.size()) begin errors++; $display("FAIL basic_len: got %0d expected %0d", got_q.size(), model_q.size()); end
        for (int i = 0; i < got_q.size() && i < model_q.size(); i++) begin
            checks++; if (got_q[i] !== model_q[i]) begin errors++; $display("FAIL basic_beat[%0d]: got %h expected %h", i, got_q[i], model_q[i]); end
        end
        checks++; if (first_valid_k < 1 || first_valid_k > 4) begin errors++; $display("FAIL basic_latency: got %0d expected <=4", first_valid_k); end
        checks++; if (last_beat_k - first_valid_k + 1 != model_q.size()) begin
            errors++; $display("FAIL basic_bubbles: span %0d expected %0d", last_beat_k - first_valid_k + 1, model_q.size());
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_cnt: got %0d expected 1", done_cnt); end
        checks++; if (count !== CW'(model_q.size())) begin errors++; $display("FAIL basic_count_after: got %0d expected %0d", count, model_q.size()); end
    endtask

    task automatic test_wrap();
        pulse_clr();
        for (int i = 0; i < 53; i++) write_one(DW'(i));
        checks++; if (wrapped !== (model_total >= DEPTH)) begin errors++; $display("FAIL wrap_flag: got %b expected 1", wrapped); end
        checks++; if (count !== CW'(model_q.size())) begin errors++; $display("FAIL wrap_count: got %0d expected %0d", count, model_q.size()); end
        do_readout(0, 0, 200);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL wrap_timeout: no RD_DONE within budget"); end
        checks++; if (got_q.size() != model_q.size()) begin errors++; $display("FAIL wrap_len: got %0d expected %0d", got_q.size(), model_q.size()); end
        for (int i = 0; i < got_q.size() && i < model_q.size(); i++) begin
            checks++; if (got_q[i] !== model_q[i]) begin errors++; $display("FAIL wrap_beat[%0d]: got %h expected %h", i, got_q[i], model_q[i]); end
        end
        checks++; if (last_beat_k - first_valid_k + 1 != model_q.size()) begin
            errors++; $display("FAIL wrap_bubbles: span %0d expected %0d", last_beat_k - first_valid_k + 1, model_q.size());
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL wrap_done_cnt: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_backpressure();
        do_readout(1, 0, 2000);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL bp_timeout: no RD_DONE within budget"); end
        checks++; if (got_q.size() != model_q.size()) begin errors++; $display("FAIL bp_len: got %0d expected %0d", got_q.size(), model_q.size()); end
        for (int i = 0; i < got_q.size() && i < model_q.size(); i++) begin
            checks++; if (got_q[i] !== model_q[i]) begin errors++; $display("FAIL bp_beat[%0d]: got %h expected %h", i, got_q[i], model_q[i]); end
        end
        checks++; if (stab_viol != 0) begin errors++; $display("FAIL bp_stable: got %0d violations expected 0", stab_viol); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_cnt: got %0d expected 1", done_cnt); end
        checks++; if (count !== CW'(model_q.size()) || wrapped !== (model_total >= DEPTH)) begin
            errors++; $display("FAIL bp_nondestructive: count %0d wrapped %b expected %0d %b", count, wrapped, model_q.size(), model_total >= DEPTH);
        end
    endtask

    task automatic test_clr();
        int beats, dn, vc;
        logic hit;
        pulse_clr();
        for (int i = 0; i < 20; i++) write_one(DW'($urandom));
        beats = 0; hit = 1'b0;
        rd_ready = 1'b1;
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (rd_valid) beats++;
            if (beats == 4) begin
                clr = 1'b1;
                hit = 1'b1;
                @(negedge clk);
                clr = 1'b0;
                break;
            end
            @(negedge clk);
        end
        model_q.delete(); model_total = 0;
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL clr_reach: only %0d beats seen expected 4", beats); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %b expected 0", rd_valid); end
        checks++; if (count !== CW'(model_q.size())) begin errors++; $display("FAIL clr_count: got %0d expected 0", count); end
        checks++; if (wrapped !== 1'b0) begin errors++; $display("FAIL clr_wrapped: got %b expected 0", wrapped); end
        dn = 0; vc = 0;
        for (int k = 0; k < 6; k++) begin
            if (rd_done) dn++;
            if (rd_valid) vc++;
            @(negedge clk);
        end
        checks++; if (dn != 0 || vc != 0) begin errors++; $display("FAIL clr_quiet: done %0d valid %0d expected 0 0", dn, vc); end
        write_one(9'h1AA);
        do_readout(0, 0, 50);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL clr_after_len: got %0d expected 1", got_q.size()); end
        checks++; if (got_q.size() > 0 && got_q[0] !== model_q[0]) begin errors++; $display("FAIL clr_after_data: got %h expected %h", got_q[0], model_q[0]); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL clr_after_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) write_one(DW'($urandom));
        rd_ready = 1'b0;
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1 || rd_valid !== 1'b1) begin errors++; $display("FAIL arst_pre: busy %b valid %b expected 1 1", busy, rd_valid); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (rd_valid !== 1'b0 || rd_done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL arst_flags: valid %b done %b busy %b expected 0 0 0", rd_valid, rd_done, busy);
        end
        checks++; if (rd_data !== 9'h000 || count !== 6'd0 || wrapped !== 1'b0) begin
            errors++; $display("FAIL arst_state: data %h count %0d wrapped %b expected 000 0 0", rd_data, count, wrapped);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rd_ready = 1'b1;
        model_q.delete(); model_total = 0;
        @(negedge clk);
        checks++; if (count !== CW'(model_q.size())) begin errors++; $display("FAIL arst_count: got %0d expected 0", count); end
    endtask

    task automatic test_small_wrap();
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] sgot_q[$];
        logic [DW-1:0] v;
        int dn;
        for (int i = 0; i < 13; i++) begin
            v = DW'($urandom);
            s_wr_en = 1'b1; s_wr_data = v;
            exp_q.push_back(v);
            if (exp_q.size() > S_DEPTH) void'(exp_q.pop_front());
            @(negedge clk);
            s_wr_en = 1'b0;
        end
        checks++; if (s_wrapped !== 1'b1 || s_count !== S_CW'(exp_q.size())) begin
            errors++; $display("FAIL small_status: wrapped %b count %0d expected 1 %0d", s_wrapped, s_count, exp_q.size());
        end
        dn = 0;
        s_rd_ready = 1'b1;
        s_rd_start = 1'b1;
        @(negedge clk);
        s_rd_start = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (s_rd_done) dn++;
            if (s_rd_valid) sgot_q.push_back(s_rd_data);
            @(negedge clk);
        end
        checks++; if (dn != 1) begin errors++; $display("FAIL small_done: got %0d expected 1", dn); end
        checks++; if (sgot_q.size() != exp_q.size()) begin errors++; $display("FAIL small_len: got %0d expected %0d", sgot_q.size(), exp_q.size()); end
        for (int i = 0; i < sgot_q.size() && i < exp_q.size(); i++) begin
            checks++; if (sgot_q[i] !== exp_q[i]) begin errors++; $display("FAIL small_beat[%0d]: got %h expected %h", i, sgot_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 3; it++) begin
            pulse_clr();
            n = $urandom_range(1, 110);
            for (int i = 0; i < n; i++) write_one(DW'($urandom));
            checks++; if (count !== CW'(model_q.size()) || wrapped !== (model_total >= DEPTH)) begin
                errors++; $display("FAIL rand_status[%0d]: count %0d wrapped %b expected %0d %b", it, count, wrapped, model_q.size(), model_total >= DEPTH);
            end
            do_readout(it % 2, 0, 3000);
            checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL rand_timeout[%0d]: no RD_DONE within budget", it); end
            checks++; if (got_q.size() != model_q.size()) begin errors++; $display("FAIL rand_len[%0d]: got %0d expected %0d", it, got_q.size(), model_q.size()); end
            for (int i = 0; i < got_q.size() && i < model_q.size(); i++) begin
                checks++; if (got_q[i] !== model_q[i]) begin errors++; $display("FAIL rand_beat[%0d][%0d]: got %h expected %h", it, i, got_q[i], model_q[i]); end
            end
            checks++; if (stab_viol != 0 || done_cnt != 1) begin
                errors++; $display("FAIL rand_handshake[%0d]: stab %0d done %0d expected 0 1", it, stab_viol, done_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_empty_readout();
        test_basic();
        test_wrap();
        test_backpressure();
        test_clr();
        test_async_reset();
        test_small_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
